// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: store size codes, FSM states and lane-mask helper for data_store_ram
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_e;

    // Right-aligned byte-lane mask for a store size; the reserved code writes nothing
    function automatic logic [3:0] size_mask(input logic [1:0] size);
        return (size == SZ_BYTE) ? 4'b0001 :
               (size == SZ_HALF) ? 4'b0011 :
               (size == SZ_WORD) ? 4'b1111 : 4'b0000;
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// store_lane_align: byte-lane enables and lane-aligned data for both words a store may touch
module store_lane_align
    import cpu_mem_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] data_i,
    output logic [3:0]  lo_be_o,
    output logic [31:0] lo_data_o,
    output logic [3:0]  hi_be_o,
    output logic [31:0] hi_data_o,
    output logic        spans_o
);

    logic [7:0]  be;
    logic [63:0] sh;

    // Shift mask and data across an 8-byte window; the upper word is the spill half
    always_comb begin
        be = {4'b0000, size_mask(size_i)} << off_i;
        sh = {32'h0, data_i} << {off_i, 3'b000};
    end

    assign lo_be_o   = be[3:0];
    assign hi_be_o   = be[7:4];
    assign lo_data_o = sh[31:0];
    assign hi_data_o = sh[63:32];
    assign spans_o   = |be[7:4];

endmodule

// File: rtl/data_store_ram.sv
// data_store_ram: little-endian word RAM with byte/half/word stores and shifted loads.
// MISALIGNED_SPLIT_EN: stores crossing a word boundary are split over two edges;
// without it they are dropped and misalign_err is set until reset.
module data_store_ram
    import cpu_mem_pkg::*;
#(
    parameter int unsigned SIZE      = 2**14,
    parameter logic [29:0] ADDR_MASK = 30'(SIZE - 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [1:0]  wr_size,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        misalign_err
);

    localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic [31:0]   mem [SIZE];
    state_e        state_q;
    logic [3:0]    spill_be_q;
    logic [31:0]   spill_data_q;
    logic [AW-1:0] spill_idx_q;
    logic          err_q;
    logic [3:0]    lo_be, hi_be, we_be;
    logic [31:0]   lo_data, hi_data, we_data;
    logic [AW-1:0] wr_idx, rd_idx, we_idx;
    logic          spans, accept;

    store_lane_align u_align (
        .off_i     (wr_addr[1:0]),
        .size_i    (wr_size),
        .data_i    (wr_data),
        .lo_be_o   (lo_be),
        .lo_data_o (lo_data),
        .hi_be_o   (hi_be),
        .hi_data_o (hi_data),
        .spans_o   (spans)
    );

    assign wr_idx = AW'(wr_addr[31:2] & ADDR_MASK);
    assign rd_idx = AW'(rd_addr[31:2] & ADDR_MASK);
    assign accept = wr_valid && (state_q == IDLE);

    // Pick the active write: latched spill half in SECOND, else the accepted first half
    always_comb begin
        we_be   = !rst_n ? 4'b0000 :
                  (state_q == SECOND) ? spill_be_q :
                  (accept && (!spans || SPLIT_EN)) ? lo_be : 4'b0000;
        we_data = (state_q == SECOND) ? spill_data_q : lo_data;
        we_idx  = (state_q == SECOND) ? spill_idx_q : wr_idx;
    end

    // Byte-lane writes into the array; contents are never reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we_be[i]) mem[we_idx][8*i +: 8] <= we_data[8*i +: 8];
    end

    // Split-store FSM with spill latch and sticky misalignment flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            spill_be_q   <= 4'b0000;
            spill_data_q <= 32'h0;
            spill_idx_q  <= '0;
            err_q        <= 1'b0;
        end else if (state_q == SECOND) begin
            state_q <= IDLE;
        end else if (accept && spans) begin
            if (SPLIT_EN) begin
                state_q      <= SECOND;
                spill_be_q   <= hi_be;
                spill_data_q <= hi_data;
                spill_idx_q  <= (wr_idx + 1'b1) & ADDR_MASK[AW-1:0];
            end else begin
                err_q <= 1'b1;
            end
        end
    end

    assign wr_ready = (state_q == IDLE);
    assign rd_data  = mem[rd_idx] >> {rd_addr[1:0], 3'b000};
`ifdef MISALIGNED_SPLIT_EN
    assign busy         = (state_q == SECOND);
    assign misalign_err = 1'b0;
`else
    assign busy         = 1'b0;
    assign misalign_err = err_q;
`endif

endmodule

// File: tb/tb_data_store_ram.sv
// tb_data_store_ram: directed and randomized stores checked against a byte-array model
module tb_data_store_ram;

    localparam int SIZE = 128;
    localparam int NB   = SIZE * 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [1:0]  wr_size = '0;
    logic [31:0] rd_addr = '0;
    logic [31:0] rd_data;
    logic        busy;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mb [NB];
    logic       m_err = 1'b0;

`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    data_store_ram #(.SIZE(SIZE)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_size      (wr_size),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .busy         (busy),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory seen as a flat byte stream that wraps at the end of the array
    function automatic void m_store(input logic [31:0] a, input logic [31:0] d,
                                    input logic [1:0] s, input bit first_only);
        int n    = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : (s == 2'd2) ? 4 : 0;
        int off  = int'(a[1:0]);
        int base = int'((a >> 2) % SIZE) * 4 + off;
        if (off + n > 4 && !SPLIT) begin
            m_err = 1'b1;
            return;
        end
        for (int k = 0; k < n; k++)
            if (!(first_only && off + k >= 4)) mb[(base + k) % NB] = d[8*k +: 8];
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        int w = int'((a >> 2) % SIZE) * 4;
        logic [31:0] v = {mb[w+3], mb[w+2], mb[w+1], mb[w]};
        return v >> (8 * int'(a[1:0]));
    endfunction

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        int n = 0;
        @(negedge clk);
        while (!wr_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n >= 8) chk("ready_timeout", {31'b0, wr_ready}, 32'd1);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_size  = s;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n >= 8) chk("busy_timeout", {31'b0, busy}, 32'd0);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a);
        rd_addr = a;
        #1;
        chk(tag, rd_data, m_read(a));
    endtask

    initial begin
        logic [31:0] a, d;
        logic [1:0]  s;
        #3;
        chk("rst_ready", {31'b0, wr_ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_err", {31'b0, misalign_err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int w = 0; w < SIZE; w++) begin
            d = $urandom;
            store(32'(w * 4), d, 2'd2);
            m_store(32'(w * 4), d, 2'd2, 1'b0);
        end
        rd_chk("init_w5", 32'h14);

        store(32'h100, 32'hDEADBEEF, 2'd2);
        m_store(32'h100, 32'hDEADBEEF, 2'd2, 1'b0);
        rd_addr = 32'h100; #1; chk("sw_rd100", rd_data, 32'hDEADBEEF);
        rd_addr = 32'h102; #1; chk("sw_rd102", rd_data, 32'h0000DEAD);

        store(32'h100, 32'h11223344, 2'd2);
        store(32'h101, 32'h000000AA, 2'd0);
        chk("sb_busy", {31'b0, busy}, 32'd0);
        m_store(32'h100, 32'h1122AA44, 2'd2, 1'b0);
        rd_addr = 32'h100; #1; chk("sb_word", rd_data, 32'h1122AA44);

`ifdef MISALIGNED_SPLIT_EN
        store(32'h103, 32'hCAFEF00D, 2'd2);
        chk("split_busy", {31'b0, busy}, 32'd1);
        chk("split_ready", {31'b0, wr_ready}, 32'd0);
        rd_addr = 32'h103; #1; chk("split_lane3", rd_data, 32'h0000000D);
        rd_chk("split_w104_old", 32'h104);
        @(negedge clk);
        m_store(32'h103, 32'hCAFEF00D, 2'd2, 1'b0);
        chk("split_idle", {31'b0, busy}, 32'd0);
        rd_addr = 32'h104; #1; chk("split_w104", rd_data & 32'h00FFFFFF, 32'h00CAFEF0);
        rd_chk("split_w104_m", 32'h104);

        store(32'h1FF, 32'h0000BEEF, 2'd1);
        wait_idle();
        m_store(32'h1FF, 32'h0000BEEF, 2'd1, 1'b0);
        rd_addr = 32'h1FF; #1; chk("wrap_last", rd_data, 32'h000000EF);
        rd_addr = 32'h000; #1; chk("wrap_w0", rd_data & 32'hFF, 32'h000000BE);
        rd_chk("wrap_w0_m", 32'h000);

        store(32'h103, 32'h55667788, 2'd2);
        m_store(32'h103, 32'h55667788, 2'd2, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst2_busy", {31'b0, busy}, 32'd0);
        chk("rst2_ready", {31'b0, wr_ready}, 32'd1);
        @(negedge clk);
        rd_chk("rst2_w104", 32'h104);
        rd_chk("rst2_w100", 32'h100);
        rst_n = 1'b1;
`else
        store(32'h101, 32'h12345678, 2'd2);
        m_store(32'h101, 32'h12345678, 2'd2, 1'b0);
        chk("mis_err", {31'b0, misalign_err}, 32'd1);
        chk("mis_busy", {31'b0, busy}, 32'd0);
        rd_chk("mis_w100", 32'h100);
        rd_chk("mis_w104", 32'h104);
        repeat (3) @(negedge clk);
        chk("mis_sticky", {31'b0, misalign_err}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mis_rst", {31'b0, misalign_err}, 32'd0);
        m_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif

        store(32'h108, 32'hFFFFFFFF, 2'd3);
        rd_chk("rsvd_noop", 32'h108);
        chk("rsvd_err", {31'b0, misalign_err}, 32'd0);

        for (int t = 0; t < 300; t++) begin
            a = $urandom;
            d = $urandom;
            s = 2'($urandom_range(0, 3));
            store(a, d, s);
            wait_idle();
            m_store(a, d, s, 1'b0);
            rd_chk("rnd_wr", a);
            rd_chk("rnd_any", $urandom);
            chk("rnd_err", {31'b0, misalign_err}, {31'b0, m_err});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
